data_memory: RTL and testbench

- Block-organised main data memory that sits directly downstream of the data cache.
- Serves the cache's 128-bit block refills (READ) and dirty-block write-backs (WRITE) over the cache's memory-side handshake: 28-bit block address and level-held request, with BUSYWAIT as the stall.
- Models a fixed multi-cycle access latency so cache miss and write-back paths see realistic stalls.

---
 rtl/data_memory_if.sv | 29 ++
 rtl/data_memory.sv | 92 +++++++++
 tb/tb_data_memory.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/data_memory_if.sv
// Memory-side block bus between the data cache (master) and the main data memory (slave).
// Handshake: READ/WRITE are level requests held by the master until BUSYWAIT is low; the
// cycle where a held request sees BUSYWAIT low is the completion cycle, READDATA valid from then on.
interface data_memory_if;
  logic         READ;
  logic         WRITE;
  logic [27:0]  ADDRESS;
  logic [127:0] WRITEDATA;
  logic [127:0] READDATA;
  logic         BUSYWAIT;

  modport master (
    output READ,
    output WRITE,
    output ADDRESS,
    output WRITEDATA,
    input  READDATA,
    input  BUSYWAIT
  );

  modport slave (
    input  READ,
    input  WRITE,
    input  ADDRESS,
    input  WRITEDATA,
    output READDATA,
    output BUSYWAIT
  );
endinterface

// File: rtl/data_memory.sv
// Block-organised main data memory behind the data cache: 128-bit block refills and
// write-backs with a fixed multi-cycle latency modelled by an IDLE/ACCESS/DONE FSM.
module data_memory #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  data_memory_if.slave      bus,
  output logic [1:0]        state
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic            op_read_q;
  logic [IW-1:0]   idx_q;
  logic [127:0]    wdata_q;
  logic [127:0]    rdata_q;
  logic [127:0]    mem [DEPTH];
  logic            commit;

  assign commit = (state_q == ACCESS) && (count_q == '0);

  // A simultaneous READ and WRITE is served as a read; the write is dropped.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.READ || bus.WRITE) begin
            op_read_q <= bus.READ;
            idx_q     <= bus.ADDRESS[IW-1:0];
            wdata_q   <= bus.WRITEDATA;
            count_q   <= CW'(LATENCY - 1);
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          if (count_q == '0) begin
            if (op_read_q) begin
              rdata_q <= mem[idx_q];
            end
            state_q <= DONE;
          end else begin
            count_q <= count_q - CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Array has no reset; a commit coinciding with RESET is abandoned.
  always_ff @(posedge CLK) begin
    if (!RESET && commit && !op_read_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // The stall must be visible in the very cycle the cache raises its request.
  always_comb begin
    bus.BUSYWAIT = 1'b0;
    if (!RESET) begin
      case (state_q)
        IDLE:    bus.BUSYWAIT = bus.READ | bus.WRITE;
        ACCESS:  bus.BUSYWAIT = 1'b1;
        default: bus.BUSYWAIT = 1'b0;
      endcase
    end
  end

  assign bus.READDATA = rdata_q;
  assign state        = state_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: latency/stall timing, refill data, back-to-back requests,
// captured-input behaviour, reset on the commit edge and address aliasing.
module tb_data_memory;

  localparam int LAT = 5;

  localparam logic [127:0] D1   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] DA5  = {16{8'hA5}};
  localparam logic [127:0] D3   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] D5   = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] D4   = 128'h40404040_41414141_42424242_43434343;
  localparam logic [127:0] D6   = 128'h66778899_AABBCCDD_EEFF0011_22334455;
  localparam logic [127:0] JUNK = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;

  logic         clk;
  logic         rst;
  logic [1:0]   dbg_state;
  int           checks;
  int           failures;
  logic [127:0] exp_q[$];
  logic [127:0] exp_rd;

  data_memory_if bus();

  data_memory #(.DEPTH(256), .LATENCY(LAT)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus),
    .state (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge; raises the request in the next cycle (cycle 0) and follows it
  // through cycle LAT+1, ending at the negedge of the DONE cycle with the request still held.
  task automatic run_req(input string tag, input logic rd, input logic wr,
                         input logic [27:0] a, input logic [127:0] d, input bit mutate);
    @(posedge clk);
    #1;
    bus.READ      = rd;
    bus.WRITE     = wr;
    bus.ADDRESS   = a;
    bus.WRITEDATA = d;
    for (int c = 0; c <= LAT + 1; c++) begin
      @(negedge clk);
      chk({tag, "_busy"}, {127'd0, bus.BUSYWAIT}, {127'd0, (c <= LAT)});
      if (c == 0) chk({tag, "_state_idle"}, {126'd0, dbg_state}, 128'd0);
      if (c == LAT + 1) chk({tag, "_state_done"}, {126'd0, dbg_state}, 128'd2);
      if (c <= LAT) begin
        @(posedge clk);
        #1;
        if (mutate && c == 1) begin
          bus.ADDRESS   = 28'h0000050;
          bus.WRITEDATA = JUNK;
        end
      end
    end
  endtask

  task automatic do_write(input string tag, input logic [27:0] a, input logic [127:0] d,
                          input bit mutate);
    run_req(tag, 1'b0, 1'b1, a, d, mutate);
    chk({tag, "_rdhold"}, bus.READDATA, exp_rd);
  endtask

  task automatic do_read(input string tag, input logic wr_too, input logic [27:0] a,
                         input logic [127:0] expv);
    exp_q.push_back(expv);
    run_req(tag, 1'b1, wr_too, a, JUNK, 1'b0);
    exp_rd = exp_q.pop_front();
    chk({tag, "_data"}, bus.READDATA, exp_rd);
  endtask

  // One idle cycle with the request dropped; READDATA must still hold.
  task automatic idle_cycle(input string tag);
    @(posedge clk);
    #1;
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_busy"}, {127'd0, bus.BUSYWAIT}, 128'd0);
    chk({tag, "_idle_rdhold"}, bus.READDATA, exp_rd);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    exp_rd        = '0;
    rst           = 1'b1;
    bus.READ      = 1'b0;
    bus.WRITE     = 1'b0;
    bus.ADDRESS   = '0;
    bus.WRITEDATA = '0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_busy", {127'd0, bus.BUSYWAIT}, 128'd0);
      chk("reset_rdata", bus.READDATA, 128'd0);
      chk("reset_state", {126'd0, dbg_state}, 128'd0);
    end

    // Plain write then read-back, READDATA held after the request drops
    do_write("wr10", 28'h0000010, D1, 1'b0);
    idle_cycle("wr10");
    do_read("rd10", 1'b0, 28'h0000010, D1);
    idle_cycle("rd10");

    // Write-back immediately followed by refill, no dead cycle
    do_write("wb20", 28'h0000020, DA5, 1'b0);
    do_read("refill10", 1'b0, 28'h0000010, D1);
    idle_cycle("refill10");
    do_read("rd20", 1'b0, 28'h0000020, DA5);
    idle_cycle("rd20");

    // Inputs changed mid-ACCESS are ignored; READ+WRITE acts as a read only
    do_write("wr50", 28'h0000050, D5, 1'b0);
    idle_cycle("wr50");
    do_write("wr30_mut", 28'h0000030, D3, 1'b1);
    idle_cycle("wr30_mut");
    do_read("rdwr30", 1'b1, 28'h0000030, D3);
    idle_cycle("rdwr30");
    do_read("rd30", 1'b0, 28'h0000030, D3);
    idle_cycle("rd30");
    do_read("rd50", 1'b0, 28'h0000050, D5);
    idle_cycle("rd50");

    // Reset landing on the commit edge of a write
    do_write("wr40", 28'h0000040, D4, 1'b0);
    idle_cycle("wr40");
    @(posedge clk);
    #1;
    bus.WRITE     = 1'b1;
    bus.ADDRESS   = 28'h0000040;
    bus.WRITEDATA = '1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_forced_busy", {127'd0, bus.BUSYWAIT}, 128'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.WRITE = 1'b0;
    exp_rd    = '0;
    @(negedge clk);
    chk("rst_commit_busy", {127'd0, bus.BUSYWAIT}, 128'd0);
    chk("rst_commit_rdata", bus.READDATA, 128'd0);
    chk("rst_commit_state", {126'd0, dbg_state}, 128'd0);
    do_read("rd40_after_rst", 1'b0, 28'h0000040, D4);
    idle_cycle("rd40_after_rst");

    // Upper address bits alias onto the same block
    do_write("wr140", 28'h0000140, D6, 1'b0);
    idle_cycle("wr140");
    do_read("rd40_alias", 1'b0, 28'h0000040, D6);
    idle_cycle("rd40_alias");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
